// File: rtl/dvp_capture_win.sv
// dvp_capture_win
//   Captures a parallel DVP camera stream, discards SKIP_FRAMES frames after
//   enable so the sensor can settle, assembles BYTES_PER_PIX bus beats into
//   one pixel and crops each frame to a window latched at frame start.
//
// Ports
//   clk, rst                  camera pixel clock; asynchronous active-high reset
//   enable                    capture enable (a running frame always completes)
//   cam_vsync/href/data       raw sensor interface
//   byte_swap                 1: first beat lands in the LSB of pix_data
//   win_x0/y0/w/h             crop window origin and size (pixels / lines)
//   frame_vsync, frame_href   delayed sync, gated to captured frames / window lines
//   pix_valid, pix_data       one-cycle strobe per in-window pixel; data holds
//   pix_x, pix_y              window-relative coordinates of pix_data
//   frame_start, frame_done   one-cycle pulses at frame boundaries
//   frame_cnt                 completed frames, wraps at 16 bits
//   busy                      FSM away from IDLE
module dvp_capture_win #(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int SKIP_FRAMES   = 10,
   parameter int CNT_W         = 13
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            cam_vsync,
   input  logic                            cam_href,
   input  logic [DATA_W-1:0]               cam_data,
   input  logic                            byte_swap,
   input  logic [CNT_W-1:0]                win_x0,
   input  logic [CNT_W-1:0]                win_y0,
   input  logic [CNT_W-1:0]                win_w,
   input  logic [CNT_W-1:0]                win_h,
   output logic                            frame_vsync,
   output logic                            frame_href,
   output logic                            pix_valid,
   output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
   output logic [CNT_W-1:0]                pix_x,
   output logic [CNT_W-1:0]                pix_y,
   output logic                            frame_start,
   output logic                            frame_done,
   output logic [15:0]                     frame_cnt,
   output logic                            busy
);

   localparam int PIX_W  = DATA_W * BYTES_PER_PIX;
   localparam int BEAT_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
   localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BYTES_PER_PIX - 1);
   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, SKIP, WAIT_VS, ACTIVE} state_t;

   state_t              state, state_nxt;
   logic [SKIP_W-1:0]   skip_cnt, skip_nxt;
   logic                start_nxt, done_nxt;

   logic                vs_d1, vs_d2, href_d1, href_d2;
   logic [DATA_W-1:0]   data_d1;
   logic                vs_rise, href_rise, href_fall;

   logic [BEAT_W-1:0]   beat_cnt, beat_idx;
   logic [CNT_W-1:0]    col_cnt, col_cur, line_cnt;
   logic [PIX_W-1:0]    acc, cur_beats, asm_pix;
   logic                pix_done, col_in_win, line_in_win, emit;

   logic [CNT_W-1:0]    x0_q, y0_q, w_q, h_q;
   logic                swap_q;

   assign vs_rise   = vs_d1 & ~vs_d2;
   assign href_rise = href_d1 & ~href_d2;
   assign href_fall = ~href_d1 & href_d2;

   // The first beat of a line is index 0 even before beat_cnt has been cleared.
   assign beat_idx = href_rise ? '0 : beat_cnt;
   assign col_cur  = href_rise ? '0 : col_cnt;
   assign pix_done = href_d1 && (beat_idx == BEAT_LAST);

   // Window bounds are compared one bit wider so x0+w never wraps.
   assign col_in_win  = (col_cur >= x0_q) &&
                        ({1'b0, col_cur} < ({1'b0, x0_q} + {1'b0, w_q}));
   assign line_in_win = (line_cnt >= y0_q) &&
                        ({1'b0, line_cnt} < ({1'b0, y0_q} + {1'b0, h_q}));

   assign emit = pix_done && col_in_win && line_in_win && (state == ACTIVE);

   assign busy        = (state != IDLE);
   assign frame_vsync = vs_d2 & ((state == ACTIVE) | frame_start);
   assign frame_href  = href_d2 & line_in_win & (state == ACTIVE);

   // Beat slots are stored in arrival order; the output order is applied last.
   always_comb begin
      cur_beats = acc;
      cur_beats[int'(beat_idx) * DATA_W +: DATA_W] = data_d1;
      asm_pix = '0;
      for (int unsigned i = 0; i < BYTES_PER_PIX; i++) begin
         if (swap_q)
            asm_pix[i*DATA_W +: DATA_W] = cur_beats[i*DATA_W +: DATA_W];
         else
            asm_pix[(BYTES_PER_PIX-1-i)*DATA_W +: DATA_W] = cur_beats[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         skip_cnt <= '0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      skip_nxt  = skip_cnt;
      start_nxt = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            skip_nxt = '0;
            if (enable) begin
               if (SKIP_FRAMES > 0) state_nxt = SKIP;
               else                 state_nxt = WAIT_VS;
            end
         end
         SKIP: begin
            if (!enable) begin
               state_nxt = IDLE;
               skip_nxt  = '0;
            end else if (vs_rise) begin
               if (skip_cnt == SKIP_LAST) begin
                  state_nxt = WAIT_VS;
                  skip_nxt  = '0;
               end else begin
                  skip_nxt = skip_cnt + 1'b1;
               end
            end
         end
         WAIT_VS: begin
            if (!enable) begin
               state_nxt = IDLE;
               skip_nxt  = '0;
            end else if (vs_rise) begin
               state_nxt = ACTIVE;
               start_nxt = 1'b1;
            end
         end
         ACTIVE: begin
            // enable is only sampled at the frame boundary.
            if (vs_rise) begin
               done_nxt = 1'b1;
               if (enable) start_nxt = 1'b1;
               else        state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_d1       <= 1'b0;
         vs_d2       <= 1'b0;
         href_d1     <= 1'b0;
         href_d2     <= 1'b0;
         data_d1     <= '0;
         beat_cnt    <= '0;
         col_cnt     <= '0;
         line_cnt    <= '0;
         acc         <= '0;
         x0_q        <= '0;
         y0_q        <= '0;
         w_q         <= '0;
         h_q         <= '0;
         swap_q      <= 1'b0;
         pix_valid   <= 1'b0;
         pix_data    <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         vs_d1   <= cam_vsync;
         vs_d2   <= vs_d1;
         href_d1 <= cam_href;
         href_d2 <= href_d1;
         data_d1 <= cam_data;

         frame_start <= start_nxt;
         frame_done  <= done_nxt;
         if (done_nxt) frame_cnt <= frame_cnt + 16'd1;

         if (start_nxt) begin
            x0_q   <= win_x0;
            y0_q   <= win_y0;
            w_q    <= win_w;
            h_q    <= win_h;
            swap_q <= byte_swap;
         end

         // A partial pixel is dropped because beat_cnt clears while href is low.
         if (href_d1) begin
            acc      <= cur_beats;
            beat_cnt <= pix_done ? '0 : beat_idx + 1'b1;
         end else begin
            beat_cnt <= '0;
         end

         if (pix_done)
            col_cnt <= (col_cur == CNT_MAX) ? col_cur : col_cur + 1'b1;
         else if (href_rise)
            col_cnt <= '0;

         if (vs_rise)
            line_cnt <= '0;
         else if (href_fall && (line_cnt != CNT_MAX))
            line_cnt <= line_cnt + 1'b1;

         // Evaluated with the pre-transition state, so a pixel finishing on the
         // same cycle as the closing vsync edge still belongs to its frame.
         pix_valid <= emit;
         if (emit) begin
            pix_data <= asm_pix;
            pix_x    <= col_cur - x0_q;
            pix_y    <= line_cnt - y0_q;
         end
      end
   end

endmodule
